// File: rtl/approx_mac_pkg.sv
// Shared definitions for the approximate Wallace-tree MAC: default
// parameters and the column-wise golden product function.
package approx_mac_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_APPROX_COLS = 4;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int MAX_WIDTH       = 16;

    // Golden product: column c contributes popcount*2^c, except the K lowest
    // columns in approximate mode, which contribute only their OR.
    function automatic logic [2*MAX_WIDTH-1:0] approx_prod(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 approx_en,
        input int                   k,
        input int                   width = DEF_WIDTH
    );
        logic [2*MAX_WIDTH-1:0] p;
        int                     cnt;
        int                     j;
        p = '0;
        for (int c = 0; c < 2*MAX_WIDTH; c++) begin
            cnt = 0;
            for (int i = 0; i < MAX_WIDTH; i++) begin
                j = c - i;
                if (i < width && j >= 0 && j < width) begin
                    if (a[j] && b[i]) begin
                        cnt++;
                    end
                end
            end
            if (approx_en && c < k) begin
                if (cnt != 0) begin
                    p = p + (32'd1 << c);
                end
            end else begin
                p = p + (32'(cnt) << c);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/approx_wallace_ppm.sv
// Combinational partial-product generator with Wallace reduction.
// In approximate mode each of the APPROX_COLS lowest columns is collapsed to
// the OR of its bits before reduction; a column holding a single bit can
// never produce a carry, so no carry leaves the approximate region and the
// exact reduction of the modified matrix yields the approximate product.
module approx_wallace_ppm
    import approx_mac_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_COLS = DEF_APPROX_COLS
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               approx_en,
    output logic [2*WIDTH-1:0] p
);

    localparam int NC      = 2*WIDTH;
    localparam int MAXH    = WIDTH + 2;
    localparam int NLAYERS = 10;

    typedef logic [MAXH-1:0] col_t;

    // Row i of the partial-product array: pp[i][j] = a[j] & b[i]
    logic [WIDTH-1:0][WIDTH-1:0] pp;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp_row
            assign pp[gi] = a & {WIDTH{b[gi]}};
        end
    endgenerate

    // Column matrix -> repeated 3:2 / 2:2 layers until every column is at
    // most two bits high -> final carry-propagate add of the two rows.
    function automatic logic [NC-1:0] wallace_sum(
        input logic [WIDTH-1:0][WIDTH-1:0] m_pp,
        input logic                        apx
    );
        col_t           m  [NC];
        col_t           mn [NC];
        int             h  [NC];
        int             hn [NC];
        int             idx;
        logic           x;
        logic           y;
        logic           z;
        logic [NC-1:0]  r0;
        logic [NC-1:0]  r1;

        for (int c = 0; c < NC; c++) begin
            m[c] = '0;
            h[c] = 0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                m[i+j][h[i+j]] = m_pp[i][j];
                h[i+j]++;
            end
        end

        // Approximate columns: the whole column becomes one OR bit
        for (int c = 0; c < NC; c++) begin
            if (apx && c < APPROX_COLS) begin
                m[c] = {{(MAXH-1){1'b0}}, |m[c]};
            end
        end

        for (int l = 0; l < NLAYERS; l++) begin
            for (int c = 0; c < NC; c++) begin
                mn[c] = '0;
                hn[c] = 0;
            end
            for (int c = 0; c < NC; c++) begin
                idx = 0;
                for (int t = 0; t <= MAXH/3; t++) begin
                    if (h[c] - idx >= 3) begin
                        x = m[c][idx];
                        y = m[c][idx+1];
                        z = m[c][idx+2];
                        mn[c][hn[c]] = x ^ y ^ z;
                        hn[c]++;
                        if (c + 1 < NC) begin
                            mn[c+1][hn[c+1]] = (x & y) | (x & z) | (y & z);
                            hn[c+1]++;
                        end
                        idx = idx + 3;
                    end
                end
                if (h[c] > 2 && h[c] - idx == 2) begin
                    x = m[c][idx];
                    y = m[c][idx+1];
                    mn[c][hn[c]] = x ^ y;
                    hn[c]++;
                    if (c + 1 < NC) begin
                        mn[c+1][hn[c+1]] = x & y;
                        hn[c+1]++;
                    end
                    idx = idx + 2;
                end
                for (int t = 0; t < MAXH; t++) begin
                    if (t >= idx && t < h[c]) begin
                        mn[c][hn[c]] = m[c][t];
                        hn[c]++;
                    end
                end
            end
            for (int c = 0; c < NC; c++) begin
                m[c] = mn[c];
                h[c] = hn[c];
            end
        end

        for (int c = 0; c < NC; c++) begin
            r0[c] = m[c][0];
            r1[c] = m[c][1];
        end
        return r0 + r1;
    endfunction

    // Whole multiplier is a single combinational evaluation of the tree
    always_comb begin
        p = wallace_sum(pp, approx_en);
    end

endmodule

// File: rtl/approx_wallace_mac.sv
// Pipelined unsigned multiply-accumulate on the approximate Wallace tree.
// S0 registers the sample, S1 registers the product, S2 accumulates.
// Optional feature macro: APPROX_MAC_SAT_EN (saturating accumulator with a
// sticky overflow flag); without it the accumulator wraps and acc_ovf is 0.
module approx_wallace_mac
    import approx_mac_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int APPROX_COLS = DEF_APPROX_COLS,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       a_in,
    input  logic [WIDTH-1:0]       b_in,
    input  logic                   approx_en,
    input  logic                   acc_clr,
    output logic [2*WIDTH-1:0]     prod_out,
    output logic                   prod_valid,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_valid,
    output logic                   acc_ovf
);

    // S0 sample registers
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 apx_q, apx_d;
    logic                 clr0_q, clr0_d;
    logic                 vld0_q, vld0_d;
    // S1 product registers
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 clr1_q, clr1_d;
    logic                 vld1_q, vld1_d;
    // S2 accumulator registers
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 acc_vld_q, acc_vld_d;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [2*WIDTH-1:0]   tree_p;
`ifdef APPROX_MAC_SAT_EN
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   sum_ext;
`else
    logic [ACC_WIDTH-1:0] sum_wrap;
`endif

    approx_wallace_ppm #(
        .WIDTH       (WIDTH),
        .APPROX_COLS (APPROX_COLS)
    ) u_ppm (
        .a         (a_q),
        .b         (b_q),
        .approx_en (apx_q),
        .p         (tree_p)
    );

    assign prod_ext = {{(ACC_WIDTH-2*WIDTH){1'b0}}, prod_q};

    // Next-state for all three stages; S2 clears, accumulates or holds
    always_comb begin
        a_d       = a_in;
        b_d       = b_in;
        apx_d     = approx_en;
        clr0_d    = acc_clr;
        vld0_d    = in_valid;
        prod_d    = tree_p;
        clr1_d    = clr0_q;
        vld1_d    = vld0_q;
        acc_vld_d = vld1_q;
        acc_d     = acc_q;
`ifdef APPROX_MAC_SAT_EN
        ovf_d     = ovf_q;
        sum_ext   = {1'b0, acc_q} + {1'b0, prod_ext};
        if (vld1_q) begin
            if (clr1_q) begin
                acc_d = prod_ext;
                ovf_d = 1'b0;
            end else if (sum_ext[ACC_WIDTH]) begin
                acc_d = {ACC_WIDTH{1'b1}};
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_ext[ACC_WIDTH-1:0];
            end
        end
`else
        sum_wrap  = acc_q + prod_ext;
        if (vld1_q) begin
            acc_d = clr1_q ? prod_ext : sum_wrap;
        end
`endif
    end

    // Pipeline and accumulator state, synchronously cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            apx_q     <= 1'b0;
            clr0_q    <= 1'b0;
            vld0_q    <= 1'b0;
            prod_q    <= '0;
            clr1_q    <= 1'b0;
            vld1_q    <= 1'b0;
            acc_q     <= '0;
            acc_vld_q <= 1'b0;
`ifdef APPROX_MAC_SAT_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            apx_q     <= apx_d;
            clr0_q    <= clr0_d;
            vld0_q    <= vld0_d;
            prod_q    <= prod_d;
            clr1_q    <= clr1_d;
            vld1_q    <= vld1_d;
            acc_q     <= acc_d;
            acc_vld_q <= acc_vld_d;
`ifdef APPROX_MAC_SAT_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign prod_out   = prod_q;
    assign prod_valid = vld1_q;
    assign acc_out    = acc_q;
    assign acc_valid  = acc_vld_q;
`ifdef APPROX_MAC_SAT_EN
    assign acc_ovf    = ovf_q;
`else
    assign acc_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_approx_wallace_mac.sv
// Self-checking bench for approx_wallace_mac (WIDTH=8, APPROX_COLS=4,
// ACC_WIDTH=24). Reference: a*b with a per-column correction for the
// approximate columns, plus an arithmetic accumulator with a 2-deep
// sample history for the pipeline latency.
module tb_approx_wallace_mac;

    localparam int     W       = 8;
    localparam int     K       = 4;
    localparam int     AW      = 24;
    localparam longint ACC_MAX = (longint'(1) << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          approx_en = 1'b0;
    logic          acc_clr = 1'b0;
    logic [2*W-1:0] prod_out;
    logic          prod_valid;
    logic [AW-1:0] acc_out;
    logic          acc_valid;
    logic          acc_ovf;

    int vectors     = 0;
    int miscompares = 0;

    approx_wallace_mac #(
        .WIDTH       (W),
        .APPROX_COLS (K),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .a_in       (a_in),
        .b_in       (b_in),
        .approx_en  (approx_en),
        .acc_clr    (acc_clr),
        .prod_out   (prod_out),
        .prod_valid (prod_valid),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .acc_ovf    (acc_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit v;
        int a;
        int b;
        bit apx;
        bit clr;
    } smp_t;

    smp_t   h1;      // sample driven one cycle ago
    smp_t   h2;      // sample driven two cycles ago
    longint m_acc;
    bit     m_ovf;
    bit     e_pv;
    bit     e_av;
    longint e_prod;

    // Exact product minus, for each approximate column, the value the
    // column loses by keeping only its OR instead of its bit count.
    function automatic longint ref_prod(int a, int b, bit apx);
        longint p;
        int     cnt;
        p = longint'(a) * longint'(b);
        if (apx) begin
            for (int c = 0; c < K; c++) begin
                cnt = 0;
                for (int i = 0; i < W; i++) begin
                    if (c - i >= 0 && c - i < W) begin
                        cnt += (a[c-i] & b[i]);
                    end
                end
                p = p - longint'(cnt) * (longint'(1) << c);
                if (cnt > 0) begin
                    p = p + (longint'(1) << c);
                end
            end
        end
        return p;
    endfunction

    // Apply one cycle of stimulus and advance the reference model
    task automatic drive_cycle(bit r, bit v, int a, int b, bit apx, bit clr);
        longint p;
        longint s;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        a_in      = a[W-1:0];
        b_in      = b[W-1:0];
        approx_en = apx;
        acc_clr   = clr;
        @(posedge clk);
        #1;
        if (r) begin
            m_acc  = 0;
            m_ovf  = 1'b0;
            e_pv   = 1'b0;
            e_av   = 1'b0;
            e_prod = 0;
            h1     = '0;
            h2     = '0;
        end else begin
            e_pv = h1.v;
            if (h1.v) begin
                e_prod = ref_prod(h1.a, h1.b, h1.apx);
            end
            e_av = h2.v;
            if (h2.v) begin
                p = ref_prod(h2.a, h2.b, h2.apx);
                if (h2.clr) begin
                    m_acc = p;
                    m_ovf = 1'b0;
                end else begin
                    s = m_acc + p;
                    if (s > ACC_MAX) begin
`ifdef APPROX_MAC_SAT_EN
                        m_acc = ACC_MAX;
                        m_ovf = 1'b1;
`else
                        m_acc = s % (ACC_MAX + 1);
`endif
                    end else begin
                        m_acc = s;
                    end
                end
            end
            h2 = h1;
            h1 = '{v: v, a: a & 'hFF, b: b & 'hFF, apx: apx, clr: clr};
        end
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            drive_cycle(1'b1, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
            vectors++;
            if ({prod_out, prod_valid, acc_out, acc_valid, acc_ovf} !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: prod=%h pv=%b acc=%h av=%b ovf=%b, required all 0",
                         n, prod_out, prod_valid, acc_out, acc_valid, acc_ovf);
            end
        end
        for (int n = 0; n < 3; n++) begin
            drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
            vectors++;
            if (prod_valid !== 1'b0 || acc_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_no_valid cycle %0d: pv=%b av=%b, required 0 0", n, prod_valid, acc_valid);
            end
        end
        $display("test_reset: reset and post-reset idle checked");
    endtask

    task automatic test_products();
        int  sa [5] = '{'hFF, 'hFF, 3, 3, 0};
        int  sb [5] = '{'hFF, 'hFF, 3, 5, 0};
        bit  sx [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        bit  sv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int  ep [4] = '{'hFE01, 'hFDDF, 7, 15};
        for (int n = 0; n < 5; n++) begin
            drive_cycle(1'b0, sv[n], sa[n], sb[n], sx[n], n == 0);
            if (n > 0) begin
                vectors++;
                if (prod_valid !== 1'b1 || prod_out !== ep[n-1][2*W-1:0]) begin
                    miscompares++;
                    $display("FAIL product_%0d: prod=%h pv=%b, required %h 1", n-1, prod_out, prod_valid, ep[n-1]);
                end
                $display("product a=%0h b=%0h apx=%b -> %h", sa[n-1], sb[n-1], sx[n-1], prod_out);
            end
        end
        drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        vectors++;
        if (prod_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL product_idle: pv=%b, required 0", prod_valid);
        end
    endtask

    task automatic test_back_to_back();
        int sa [6] = '{3, 2, 1, 0, 0, 0};
        int sb [6] = '{5, 2, 1, 0, 0, 0};
        bit sv [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int ea [4] = '{15, 19, 20, 20};
        bit ev [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int n = 0; n < 6; n++) begin
            drive_cycle(1'b0, sv[n], sa[n], sb[n], 1'b0, n == 0);
            if (n >= 2) begin
                vectors++;
                if (acc_out !== AW'(ea[n-2]) || acc_valid !== ev[n-2]) begin
                    miscompares++;
                    $display("FAIL back_to_back_%0d: acc=%0d av=%b, required %0d %b",
                             n-2, acc_out, acc_valid, ea[n-2], ev[n-2]);
                end
                $display("accumulate step %0d: acc=%0d av=%b", n-2, acc_out, acc_valid);
            end
        end
    endtask

    task automatic test_overflow();
        longint exp_acc;
        bit     exp_ovf;
`ifdef APPROX_MAC_SAT_EN
        exp_acc = ACC_MAX;
        exp_ovf = 1'b1;
`else
        exp_acc = (longint'(300) * 65025) % (ACC_MAX + 1);
        exp_ovf = 1'b0;
`endif
        for (int n = 0; n < 300; n++) begin
            drive_cycle(1'b0, 1'b1, 'hFF, 'hFF, 1'b0, n == 0);
        end
        drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        vectors++;
        if (acc_out !== exp_acc[AW-1:0] || acc_ovf !== exp_ovf) begin
            miscompares++;
            $display("FAIL overflow_300: acc=%0d ovf=%b, required %0d %b", acc_out, acc_ovf, exp_acc, exp_ovf);
        end
        $display("overflow run: acc=%0d ovf=%b", acc_out, acc_ovf);
        drive_cycle(1'b0, 1'b1, 1, 1, 1'b0, 1'b1);
        drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        vectors++;
        if (acc_out !== AW'(1) || acc_ovf !== 1'b0 || acc_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_clear: acc=%0d ovf=%b av=%b, required 1 0 1", acc_out, acc_ovf, acc_valid);
        end
        $display("clear after overflow: acc=%0d ovf=%b", acc_out, acc_ovf);
    endtask

    task automatic test_random();
        bit r;
        for (int n = 0; n < 10000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            drive_cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
            vectors++;
            if (prod_valid !== e_pv || acc_valid !== e_av) begin
                miscompares++;
                $display("FAIL random_valid cycle %0d: pv=%b av=%b, required %b %b", n, prod_valid, acc_valid, e_pv, e_av);
            end
            if (e_pv) begin
                vectors++;
                if (prod_out !== e_prod[2*W-1:0]) begin
                    miscompares++;
                    $display("FAIL random_prod cycle %0d: prod=%h, required %h", n, prod_out, e_prod[2*W-1:0]);
                end
            end
            vectors++;
            if (acc_out !== m_acc[AW-1:0] || acc_ovf !== m_ovf) begin
                miscompares++;
                $display("FAIL random_acc cycle %0d: acc=%h ovf=%b, required %h %b", n, acc_out, acc_ovf, m_acc[AW-1:0], m_ovf);
            end
            if (n % 1000 == 999) begin
                $display("random: %0d samples, acc=%h", n + 1, acc_out);
            end
        end
    endtask

    initial begin
        h1     = '0;
        h2     = '0;
        m_acc  = 0;
        m_ovf  = 1'b0;
        e_pv   = 1'b0;
        e_av   = 1'b0;
        e_prod = 0;
        test_reset();
        test_products();
        test_back_to_back();
        test_overflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
